// File: rtl/fifo_share_arbiter_if.sv
// rtl/fifo_share_arbiter_if.sv - producer/FIFO-side signal bundle for the shared FIFO write arbiter
interface fifo_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 8
);
  localparam int OW   = $clog2(NREQ);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [NREQ-1:0]         req;
  logic [NREQ-1:0][DW-1:0] wdata_in;
  logic [NREQ-1:0]         last;
  logic [NREQ-1:0]         gnt;
  logic                    fifo_wen;
  logic [DW-1:0]           fifo_wdata;
  logic                    fifo_clear;
  logic                    fifo_full;
  logic                    fifo_overrun;
  logic [CNTW-1:0]         fifo_count;
  logic                    flush;
  logic                    busy;
  logic [OW-1:0]           owner;
  logic                    err;
  logic [CNTW-1:0]         level;

  modport master (
    output req, wdata_in, last, fifo_full, fifo_overrun, fifo_count, flush,
    input  gnt, fifo_wen, fifo_wdata, fifo_clear, busy, owner, err, level
  );

  modport slave (
    input  req, wdata_in, last, fifo_full, fifo_overrun, fifo_count, flush,
    output gnt, fifo_wen, fifo_wdata, fifo_clear, busy, owner, err, level
  );
endinterface

// File: rtl/fifo_share_arbiter.sv
// rtl/fifo_share_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among NREQ producers
module fifo_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int BURST = 4
) (
  input logic                CLK,
  input logic                nRST,
  fifo_share_arbiter_if.slave bus
);
  localparam int OW   = $clog2(NREQ);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int BW   = $clog2(BURST + 1);
  localparam logic [BW-1:0] BURST_C = BW'(BURST);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            err_q, err_d;
  logic [CNTW-1:0] level_q;

  logic [OW-1:0]   pick_idx;
  logic [OW-1:0]   owner_inc;
  logic            pick_found;
  logic            grant_ok;
  logic            beat;
  int              scan_idx;

  // Walk downward so the requester closest to ptr (smallest offset) wins.
  always_comb begin : rr_pick
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    scan_idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = (int'(ptr_q) + k) % NREQ;
      if (bus.req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = OW'(scan_idx);
      end
    end
  end

  assign owner_inc = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

  // Full and flush gate the grant in the same cycle so the FIFO never sees WEN while full.
  assign grant_ok = (state_q == S_GRANT) & ~bus.fifo_full & ~bus.flush;
  assign beat     = grant_ok & bus.req[owner_q];

  assign bus.gnt        = grant_ok ? (NREQ'(1) << owner_q) : '0;
  assign bus.fifo_wen   = beat;
  assign bus.fifo_wdata = bus.wdata_in[owner_q];
  assign bus.fifo_clear = bus.flush;
  assign bus.busy       = (state_q == S_GRANT);
  assign bus.owner      = owner_q;
  assign bus.err        = err_q;
  assign bus.level      = level_q;

  always_comb begin : next_state
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    if (bus.flush) begin
      state_d    = S_IDLE;
      beat_cnt_d = '0;
      err_d      = 1'b0;
    end else begin
      if (bus.fifo_overrun) err_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            owner_d    = pick_idx;
            beat_cnt_d = '0;
            state_d    = S_GRANT;
          end
        end
        S_GRANT: begin
          // A withdrawn request releases even while stalled on full.
          if (!bus.req[owner_q]) begin
            state_d = S_IDLE;
            ptr_d   = owner_inc;
          end else if (beat) begin
            beat_cnt_d = beat_cnt_q + BW'(1);
            if (bus.last[owner_q] || (beat_cnt_d == BURST_C)) begin
              state_d = S_IDLE;
              ptr_d   = owner_inc;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      level_q    <= bus.fifo_count;
    end
  end
endmodule

// File: tb/tb_fifo_share_arbiter.sv
// tb/tb_fifo_share_arbiter.sv - directed and randomized bench for fifo_share_arbiter against a reference model
module tb_fifo_share_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int BURST = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_share_arbiter_if #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) bus ();

  fifo_share_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .BURST(BURST)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: arbitration state kept as plain integers.
  bit              m_busy;
  int              m_ptr, m_owner, m_beats;
  bit              m_err;
  int              m_level;
  logic [NREQ-1:0] exp_gnt;
  logic [NREQ-1:0] acc;
  int              wen_seen = 0;

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_owner = 0; m_beats = 0; m_err = 0; m_level = 0;
  endtask

  task automatic model_release();
    m_busy = 0;
    m_ptr  = (m_owner + 1) % NREQ;
  endtask

  task automatic model_step();
    bit found;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (bus.flush) begin
      m_busy = 0; m_beats = 0; m_err = 0;
    end else begin
      if (bus.fifo_overrun) m_err = 1;
      if (!m_busy) begin
        found = 0;
        for (int k = 0; k < NREQ; k++) begin
          if (!found && bus.req[(m_ptr + k) % NREQ]) begin
            found = 1; m_owner = (m_ptr + k) % NREQ; m_busy = 1; m_beats = 0;
          end
        end
      end else if (!bus.req[m_owner]) begin
        model_release();
      end else if (!bus.fifo_full) begin
        m_beats++;
        if (bus.last[m_owner] || m_beats == BURST) model_release();
      end
    end
    m_level = int'(bus.fifo_count);
  endtask

  task automatic check_outputs();
    exp_gnt = '0;
    if (rst_n && m_busy && !bus.fifo_full && !bus.flush) exp_gnt[m_owner] = 1'b1;
    acc = exp_gnt & bus.req;
    check_eq("gnt",   32'(bus.gnt),        32'(exp_gnt));
    check_eq("wen",   32'(bus.fifo_wen),   32'(acc != '0));
    if (acc != '0) check_eq("wdata", 32'(bus.fifo_wdata), 32'(bus.wdata_in[m_owner]));
    check_eq("clear", 32'(bus.fifo_clear), 32'(bus.flush));
    check_eq("busy",  32'(bus.busy),       32'(m_busy));
    check_eq("owner", 32'(bus.owner),      32'(m_owner));
    check_eq("err",   32'(bus.err),        32'(m_err));
    check_eq("level", 32'(bus.level),      32'(m_level));
  endtask

  // One clock: check at the falling edge, advance the model, then return just after the rising edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    if (bus.fifo_wen === 1'b1) wen_seen++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_out();
    bus.req = '0; bus.last = '0;
    step(); step();
  endtask

  task automatic random_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req[i] && !acc[i]) begin
        if ($urandom_range(0, 19) == 0) bus.req[i] = 1'b0;
      end else begin
        bus.req[i]      = 1'($urandom_range(0, 1));
        bus.wdata_in[i] = DW'($urandom);
        bus.last[i]     = ($urandom_range(0, 3) == 0);
      end
    end
    bus.fifo_full    = ($urandom_range(0, 4) == 0);
    bus.flush        = ($urandom_range(0, 24) == 0);
    bus.fifo_overrun = ($urandom_range(0, 29) == 0);
    bus.fifo_count   = CW'($urandom_range(0, DEPTH));
  endtask

  int beats, stall, w;
  bit stalled, found_gnt;

  initial begin
    rst_n = 1'b0;
    bus.req = '0; bus.last = '0; bus.wdata_in = '0;
    bus.fifo_full = 1'b0; bus.fifo_overrun = 1'b0; bus.fifo_count = '0; bus.flush = 1'b0;
    model_reset();
    acc = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_gnt",  32'(bus.gnt),  32'd0);
    rst_n = 1'b1;
    step();

    // Single stream of three beats from requester 1.
    bus.req = 4'b0010; bus.wdata_in[1] = 8'hA1; bus.last[1] = 1'b0;
    beats = 0; w = wen_seen;
    for (int c = 0; c < 10 && beats < 3; c++) begin
      step();
      if (acc[1]) begin
        beats++;
        bus.wdata_in[1] = 8'(8'hA1 + beats);
        bus.last[1]     = (beats == 2);
        if (beats == 3) bus.req[1] = 1'b0;
      end
    end
    check_eq("single_beats", 32'(wen_seen - w), 32'd3);
    check_eq("single_idle",  32'(bus.busy), 32'd0);
    bus.last = '0;
    bus.req = 4'b0101;
    step();
    check_eq("single_ptr_owner", 32'(bus.owner), 32'd2);
    idle_out();

    // Contention: all four requesters held, no last.
    bus.req = 4'b1111;
    found_gnt = 0; w = wen_seen;
    for (int c = 0; c < 10 && !found_gnt; c++) begin
      w = wen_seen;
      step();
      if (acc != '0) found_gnt = 1;
    end
    check_eq("cont_first_gnt", 32'(found_gnt), 32'd1);
    for (int c = 0; c < 23; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) if (acc[i]) bus.wdata_in[i] = DW'($urandom);
    end
    check_eq("cont_writes", 32'(wen_seen - w), 32'd20);
    idle_out();

    // Full stall for three cycles after two beats of requester 0.
    bus.req = 4'b0001;
    beats = 0; stall = 0; stalled = 0; w = wen_seen;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      step();
      if (acc[0]) begin beats++; bus.wdata_in[0] = DW'($urandom); end
      if (stall > 0) begin
        stall--;
        if (stall == 0) bus.fifo_full = 1'b0;
      end else if (beats == 2 && !stalled) begin
        bus.fifo_full = 1'b1; stall = 3; stalled = 1;
      end
    end
    check_eq("full_beats", 32'(wen_seen - w), 32'd4);
    check_eq("full_idle",  32'(bus.busy), 32'd0);
    idle_out();

    // Withdrawal: requester 1 drops after two beats, requester 3 takes over.
    bus.req = 4'b1010;
    beats = 0;
    for (int c = 0; c < 10 && beats < 2; c++) begin
      step();
      if (acc[1]) begin beats++; bus.wdata_in[1] = DW'($urandom); end
    end
    bus.req[1] = 1'b0;
    w = wen_seen;
    step();
    check_eq("wd_no_wen", 32'(wen_seen - w), 32'd0);
    check_eq("wd_idle",   32'(bus.busy), 32'd0);
    step();
    check_eq("wd_busy",   32'(bus.busy), 32'd1);
    check_eq("wd_owner",  32'(bus.owner), 32'd3);
    idle_out();

    // Overrun sets err; flush on the second beat clears it and aborts the grant.
    bus.fifo_overrun = 1'b1;
    step();
    bus.fifo_overrun = 1'b0;
    check_eq("ovr_err", 32'(bus.err), 32'd1);
    bus.req = 4'b0100;
    beats = 0;
    for (int c = 0; c < 10 && beats < 1; c++) begin
      step();
      if (acc[2]) begin beats++; bus.wdata_in[2] = DW'($urandom); end
    end
    bus.flush = 1'b1;
    w = wen_seen;
    step();
    bus.flush = 1'b0;
    check_eq("flush_no_wen", 32'(wen_seen - w), 32'd0);
    check_eq("flush_idle",   32'(bus.busy), 32'd0);
    check_eq("flush_err",    32'(bus.err), 32'd0);
    bus.req = 4'b1100;
    step();
    check_eq("flush_ptr_owner", 32'(bus.owner), 32'd2);
    idle_out();

    // Asynchronous reset in the middle of a grant.
    bus.fifo_count = CW'(5);
    bus.fifo_overrun = 1'b1;
    bus.req = 4'b1111;
    step();
    bus.fifo_overrun = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_busy",  32'(bus.busy),     32'd0);
    check_eq("arst_owner", 32'(bus.owner),    32'd0);
    check_eq("arst_err",   32'(bus.err),      32'd0);
    check_eq("arst_level", 32'(bus.level),    32'd0);
    check_eq("arst_gnt",   32'(bus.gnt),      32'd0);
    check_eq("arst_wen",   32'(bus.fifo_wen), 32'd0);
    bus.req = '0;
    step(); step();
    rst_n = 1'b1;
    bus.req = 4'b0100;
    step();
    check_eq("arst_gnt2",   32'(bus.gnt),   32'b0100);
    check_eq("arst_owner2", 32'(bus.owner), 32'd2);
    idle_out();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      random_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_share_arbiter.md
# fifo_share_arbiter

Round-robin write-port arbiter that shares one socetlib FIFO (operand/scratchpad staging FIFO in the tensor core) among NREQ producer streams. It grants the FIFO write port to one requester at a time for a bounded burst, never writes into a full FIFO, and supports a synchronous flush that clears the FIFO and aborts the current grant. Sits between the load/DMA producers and the FIFO's WEN/wdata/clear inputs.

## Interface
- NREQ, 4, number of requesters (≥2)
- DW, 8, data width (matches FIFO element type)
- DEPTH, 8, FIFO depth (sizes fifo_count)
- BURST, 4, max beats per grant (≥1)

- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- req  in  NREQ  requester i has valid data
- wdata_in  in  NREQ×DW  per-requester data
- last  in  NREQ  requester i's current beat is its final beat
- gnt  out  NREQ  one-hot (or zero) grant; beat accepted when gnt[i] & req[i]
- fifo_wen  out  1  to FIFO WEN
- fifo_wdata  out  DW  to FIFO wdata
- fifo_clear  out  1  to FIFO clear
- fifo_full  in  1  from FIFO full
- fifo_overrun  in  1  from FIFO overrun
- fifo_count  in  $clog2(DEPTH+1)  from FIFO count (status only, mirrored to level)
- flush  in  1  abort grant, clear FIFO
- busy  out  1  state is GRANT
- owner  out  $clog2(NREQ)  current/last granted requester
- err  out  1  sticky: FIFO overrun seen
- level  out  $clog2(DEPTH+1)  registered copy of fifo_count

## Operation
- State: IDLE, GRANT. Registers: ptr (rr priority start), owner, beat_cnt ($clog2(BURST+1) bits), err, level.
- IDLE: if any req, owner ← first i with req[i] scanning ptr, ptr+1, … mod NREQ; beat_cnt ← 0; → GRANT. No grant issued in IDLE.
- GRANT: gnt[owner] = ~fifo_full & ~flush; all other gnt = 0.
- Beat: fifo_wen = gnt[owner] & req[owner]; fifo_wdata = wdata_in[owner] (combinational); beat_cnt += 1 on beat.
- Release (GRANT → IDLE, ptr ← owner+1 mod NREQ) when any of: beat with last[owner]; beat making beat_cnt == BURST; req[owner] low in GRANT (requester withdrew; no beat).
- fifo_full in GRANT: gnt held low, no release, beat_cnt holds; resumes when full drops.
- flush (any state, highest priority): fifo_clear = flush (combinational), no gnt/wen that cycle, next state IDLE, beat_cnt ← 0, err ← 0; ptr unchanged.
- err ← 1 when fifo_overrun sampled high (not during flush); cleared only by flush or reset.
- level ← fifo_count every cycle.
- gnt never asserted for a requester with req low at arbitration; one-hot guaranteed.

## Timing
- Reset (nRST low, async): state IDLE, ptr 0, owner 0, beat_cnt 0, err 0, level 0; gnt 0, fifo_wen 0, fifo_clear 0 (unless flush), busy 0.
- Arbitration latency: req high in cycle N (IDLE) → gnt earliest cycle N+1.
- Throughput: BURST beats in BURST+1 cycles per grant; one dead IDLE cycle between grants.
- Release decided on the beat cycle; IDLE next cycle; new owner granted cycle after that.
- Requester must hold wdata_in/last stable while req high until beat accepted.
- fifo_full evaluated same cycle as write; FIFO never receives WEN while full.

## Test plan
- Reset: assert nRST low mid-GRANT → all outputs/regs to reset values immediately; after release, req[2]=1 → owner=2, gnt=4'b0100 one cycle later.
- Single stream: req[1] 3 beats (0xA1,0xA2,0xA3, last on 3rd) → fifo_wen 3 consecutive cycles, data in order, IDLE after, ptr=2.
- Contention: req[0..3] all held, BURST=4, no last → grants 0,1,2,3,0 each 4 beats, 1 dead cycle between, 20 writes in 24 cycles after first gnt.
- Full stall: fifo_full high 3 cycles mid-burst of req[0] → gnt/wen low those cycles, beat_cnt preserved, burst completes with 4 total beats.
- Withdrawal: owner drops req after 2 beats → IDLE next cycle, next requester granted, no spurious wen.
- Flush mid-burst + overrun: pulse fifo_overrun → err=1; flush during GRANT beat 2 → fifo_clear=1 that cycle, no wen, IDLE, err=0, ptr unchanged.
